// File: rtl/celement_exe_nway.sv
// celement_exe_nway
//   Clocked N-way exclusive-branch / copy C-element stage. Tokens (payload plus
//   routing) arrive on one SEND/ACK channel. They are buffered in a DEPTH-entry
//   FIFO. Each token is then delivered to exactly one output channel (branch)
//   or to a subset of the output channels (copy). A copied token retires only
//   after every selected channel has acknowledged it.
//
// Ports
//   CLK, RESETN      clock (rising edge), asynchronous active-low reset
//   SENDIN/ACKOUT    upstream handshake (ACKOUT is registered !full)
//   DATAIN           upstream payload
//   EXBIN            1 = branch to channel SELIN, 0 = copy to channels in MASKIN
//   SELIN, MASKIN    routing for the incoming token
//   SENDOUT/ACKIN    per-channel downstream handshake
//   DATAOUT          head payload, shared by all channels (0 when empty)
//   CP               one-cycle pulse after the head token retires
//   FEBOUT           head token partially delivered
//   ERR              sticky: a malformed token was received
//   COUNT            FIFO occupancy
module celement_exe_nway #(
    parameter int NOUT  = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 2,
    parameter int SW    = $clog2(NOUT),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic            CLK,
    input  logic            RESETN,
    input  logic            SENDIN,
    output logic            ACKOUT,
    input  logic [DW-1:0]   DATAIN,
    input  logic            EXBIN,
    input  logic [SW-1:0]   SELIN,
    input  logic [NOUT-1:0] MASKIN,
    output logic [NOUT-1:0] SENDOUT,
    input  logic [NOUT-1:0] ACKIN,
    output logic [DW-1:0]   DATAOUT,
    output logic            CP,
    output logic            FEBOUT,
    output logic            ERR,
    output logic [CW-1:0]   COUNT
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_DELIVER = 2'd1,
        ST_PARTIAL = 2'd2
    } head_state_t;

    logic [DW-1:0]   mem_data [DEPTH];
    logic [NOUT-1:0] mem_mask [DEPTH];

    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, count_nxt;
    logic [NOUT-1:0] done, done_nxt;
    head_state_t     state, state_nxt;
    logic            ack_reg, cp_reg, err_reg;

    logic            head_valid;
    logic [NOUT-1:0] pending;
    logic [NOUT-1:0] delivered;
    logic [NOUT-1:0] dest_mask;
    logic            accept, malformed, push, retire;

    function automatic logic [NOUT-1:0] onehot(input logic [SW-1:0] sel);
        logic [NOUT-1:0] m;
        m = '0;
        for (int i = 0; i < NOUT; i++) begin
            if (int'(sel) == i) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Head state register plus the control state that moves with it.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state   <= ST_EMPTY;
            count   <= '0;
            done    <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ack_reg <= 1'b0;
            cp_reg  <= 1'b0;
            err_reg <= 1'b0;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            done    <= done_nxt;
            ack_reg <= (count_nxt != CW'(DEPTH));
            cp_reg  <= retire;
            if (push)               wr_ptr  <= wr_ptr + PW'(1);
            if (retire)             rd_ptr  <= rd_ptr + PW'(1);
            if (accept && malformed) err_reg <= 1'b1;
        end
    end

    // Payload storage carries no reset: empty entries are never observed
    // because DATAOUT and SENDOUT are gated by the head state.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_data[wr_ptr] <= DATAIN;
            mem_mask[wr_ptr] <= dest_mask;
        end
    end

    always_comb begin
        head_valid = (state != ST_EMPTY);
        pending    = head_valid ? (mem_mask[rd_ptr] & ~done) : '0;
        delivered  = pending & ACKIN;
        // Retire once no selected channel is left waiting after this edge.
        retire     = head_valid && ((pending & ~delivered) == '0);

        accept     = SENDIN & ack_reg;
        dest_mask  = EXBIN ? onehot(SELIN) : MASKIN;
        malformed  = EXBIN ? (int'(SELIN) >= NOUT) : (MASKIN == '0);
        push       = accept & ~malformed;

        count_nxt  = count;
        unique case ({push, retire})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase

        done_nxt = retire ? '0 : (done | delivered);

        state_nxt = ST_DELIVER;
        if (count_nxt == '0)      state_nxt = ST_EMPTY;
        else if (done_nxt != '0)  state_nxt = ST_PARTIAL;

        SENDOUT = pending;
        DATAOUT = head_valid ? mem_data[rd_ptr] : '0;
        FEBOUT  = (state == ST_PARTIAL);
        ACKOUT  = ack_reg;
        CP      = cp_reg;
        ERR     = err_reg;
        COUNT   = count;
    end

endmodule

// File: tb/tb_celement_exe_nway.sv
module tb_celement_exe_nway;

    localparam int NOUT  = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 2;
    localparam int SW    = 3;   // wide enough to present out-of-range selects
    localparam int CW    = 2;

    logic            CLK = 1'b0;
    logic            RESETN;
    logic            SENDIN;
    logic            ACKOUT;
    logic [DW-1:0]   DATAIN;
    logic            EXBIN;
    logic [SW-1:0]   SELIN;
    logic [NOUT-1:0] MASKIN;
    logic [NOUT-1:0] SENDOUT;
    logic [NOUT-1:0] ACKIN;
    logic [DW-1:0]   DATAOUT;
    logic            CP;
    logic            FEBOUT;
    logic            ERR;
    logic [CW-1:0]   COUNT;

    always #5 CLK = ~CLK;

    celement_exe_nway #(
        .NOUT(NOUT), .DW(DW), .DEPTH(DEPTH), .SW(SW), .CW(CW)
    ) dut (
        .CLK(CLK), .RESETN(RESETN), .SENDIN(SENDIN), .ACKOUT(ACKOUT),
        .DATAIN(DATAIN), .EXBIN(EXBIN), .SELIN(SELIN), .MASKIN(MASKIN),
        .SENDOUT(SENDOUT), .ACKIN(ACKIN), .DATAOUT(DATAOUT), .CP(CP),
        .FEBOUT(FEBOUT), .ERR(ERR), .COUNT(COUNT)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic            send;
        logic            exb;
        logic [SW-1:0]   sel;
        logic [NOUT-1:0] mask;
        logic [DW-1:0]   data;
        logic [NOUT-1:0] ack;
        logic [NOUT-1:0] e_send;
        logic [DW-1:0]   e_data;
        logic [CW-1:0]   e_cnt;
        logic            e_ack;
        logic            e_cp;
        logic            e_feb;
        logic            e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic send, input logic exb, input int sel,
                                input logic [NOUT-1:0] mask, input logic [DW-1:0] data,
                                input logic [NOUT-1:0] ack, input logic [NOUT-1:0] e_send,
                                input logic [DW-1:0] e_data, input int e_cnt,
                                input logic e_ack, input logic e_cp, input logic e_feb,
                                input logic e_err);
        vec_t v;
        v.send = send; v.exb = exb; v.sel = SW'(sel); v.mask = mask; v.data = data;
        v.ack = ack; v.e_send = e_send; v.e_data = e_data; v.e_cnt = CW'(e_cnt);
        v.e_ack = e_ack; v.e_cp = e_cp; v.e_feb = e_feb; v.e_err = e_err;
        return v;
    endfunction

    task automatic drive(input logic send, input logic exb, input logic [SW-1:0] sel,
                         input logic [NOUT-1:0] mask, input logic [DW-1:0] data,
                         input logic [NOUT-1:0] ack);
        SENDIN = send; EXBIN = exb; SELIN = sel; MASKIN = mask; DATAIN = data; ACKIN = ack;
    endtask

    task automatic chk_all(input string tag, input logic [NOUT-1:0] e_send,
                           input logic [DW-1:0] e_data, input logic [CW-1:0] e_cnt,
                           input logic e_ack, input logic e_cp, input logic e_feb,
                           input logic e_err);
        chk({tag, " SENDOUT"}, 32'(SENDOUT), 32'(e_send));
        chk({tag, " DATAOUT"}, 32'(DATAOUT), 32'(e_data));
        chk({tag, " COUNT"},   32'(COUNT),   32'(e_cnt));
        chk({tag, " ACKOUT"},  32'(ACKOUT),  32'(e_ack));
        chk({tag, " CP"},      32'(CP),      32'(e_cp));
        chk({tag, " FEBOUT"},  32'(FEBOUT),  32'(e_feb));
        chk({tag, " ERR"},     32'(ERR),     32'(e_err));
    endtask

    // Reference model: an ordered queue of pending tokens plus the set of
    // channels that have already taken the head token.
    typedef struct {
        logic [DW-1:0]   data;
        logic [NOUT-1:0] mask;
    } tok_t;

    tok_t            mq[$];
    logic [NOUT-1:0] m_done;
    logic            m_ack, m_cp, m_err;

    function automatic logic [NOUT-1:0] m_sendout();
        if (mq.size() == 0) return '0;
        return mq[0].mask & ~m_done;
    endfunction

    task automatic model_edge();
        logic [NOUT-1:0] want, got;
        logic            took;
        tok_t            t;
        took = SENDIN && m_ack;
        want = m_sendout();
        got  = want & ACKIN;
        m_cp = 1'b0;
        if (mq.size() != 0) begin
            if ((want & ~got) == '0) begin
                void'(mq.pop_front());
                m_done = '0;
                m_cp   = 1'b1;
            end else begin
                m_done = m_done | got;
            end
        end
        if (took) begin
            if (EXBIN ? (int'(SELIN) >= NOUT) : (MASKIN == '0)) begin
                m_err = 1'b1;
            end else begin
                t.data = DATAIN;
                t.mask = EXBIN ? NOUT'(1 << SELIN) : MASKIN;
                mq.push_back(t);
            end
        end
        m_ack = (mq.size() < DEPTH);
    endtask

    initial begin
        RESETN = 1'b0;
        drive(0, 0, '0, '0, '0, '0);

        // Directed vectors: inputs applied in a cycle and the outputs seen
        // during that same cycle (before the edge).
        // branch to ch2
        tbl.push_back(mk(0,0,0,4'b0000,8'h00,4'b0100, 4'b0000,8'h00,0,0,0,0,0));
        tbl.push_back(mk(1,1,2,4'b0000,8'hA5,4'b0100, 4'b0000,8'h00,0,1,0,0,0));
        tbl.push_back(mk(0,0,0,4'b0000,8'h00,4'b0100, 4'b0100,8'hA5,1,1,0,0,0));
        tbl.push_back(mk(0,0,0,4'b0000,8'h00,4'b0000, 4'b0000,8'h00,0,1,1,0,0));
        tbl.push_back(mk(0,0,0,4'b0000,8'h00,4'b0000, 4'b0000,8'h00,0,1,0,0,0));
        // copy 1011, acks ch0, (stray ch2), ch3, ch1
        tbl.push_back(mk(1,0,0,4'b1011,8'h3C,4'b0000, 4'b0000,8'h00,0,1,0,0,0));
        tbl.push_back(mk(0,0,0,4'b0000,8'h00,4'b0001, 4'b1011,8'h3C,1,1,0,0,0));
        tbl.push_back(mk(0,0,0,4'b0000,8'h00,4'b0101, 4'b1010,8'h3C,1,1,0,1,0));
        tbl.push_back(mk(0,0,0,4'b0000,8'h00,4'b1000, 4'b1010,8'h3C,1,1,0,1,0));
        tbl.push_back(mk(0,0,0,4'b0000,8'h00,4'b0000, 4'b0010,8'h3C,1,1,0,1,0));
        tbl.push_back(mk(0,0,0,4'b0000,8'h00,4'b0010, 4'b0010,8'h3C,1,1,0,1,0));
        tbl.push_back(mk(0,0,0,4'b0000,8'h00,4'b0000, 4'b0000,8'h00,0,1,1,0,0));
        // malformed: empty copy mask, then select 5
        tbl.push_back(mk(1,0,0,4'b0000,8'h11,4'b0000, 4'b0000,8'h00,0,1,0,0,0));
        tbl.push_back(mk(1,1,5,4'b0000,8'h22,4'b0000, 4'b0000,8'h00,0,1,0,0,1));
        tbl.push_back(mk(0,0,0,4'b0000,8'h00,4'b0000, 4'b0000,8'h00,0,1,0,0,1));
        // back-to-back branch tokens, all channels ready, 8 tokens
        for (int i = 0; i < 8; i++) begin
            tbl.push_back(mk(1,1,i%4,4'b0000,8'(8'h50+i),4'b1111,
                             (i == 0) ? 4'b0000 : NOUT'(1 << ((i-1)%4)),
                             (i == 0) ? 8'h00 : 8'(8'h50+i-1),
                             (i == 0) ? 0 : 1, 1, (i >= 2), 0, 1));
        end
        tbl.push_back(mk(0,0,0,4'b0000,8'h00,4'b1111, 4'b1000,8'h57,1,1,1,0,1));
        tbl.push_back(mk(0,0,0,4'b0000,8'h00,4'b1111, 4'b0000,8'h00,0,1,1,0,1));
        tbl.push_back(mk(0,0,0,4'b0000,8'h00,4'b0000, 4'b0000,8'h00,0,1,0,0,1));
        // fill with no downstream ready, hold third token, then drain
        tbl.push_back(mk(1,1,1,4'b0000,8'h61,4'b0000, 4'b0000,8'h00,0,1,0,0,1));
        tbl.push_back(mk(1,1,2,4'b0000,8'h62,4'b0000, 4'b0010,8'h61,1,1,0,0,1));
        tbl.push_back(mk(1,1,3,4'b0000,8'h63,4'b0000, 4'b0010,8'h61,2,0,0,0,1));
        tbl.push_back(mk(1,1,3,4'b0000,8'h63,4'b1111, 4'b0010,8'h61,2,0,0,0,1));
        tbl.push_back(mk(1,1,3,4'b0000,8'h63,4'b0000, 4'b0100,8'h62,1,1,1,0,1));
        tbl.push_back(mk(0,0,0,4'b0000,8'h00,4'b0100, 4'b0100,8'h62,2,0,0,0,1));
        tbl.push_back(mk(0,0,0,4'b0000,8'h00,4'b1000, 4'b1000,8'h63,1,1,1,0,1));
        tbl.push_back(mk(0,0,0,4'b0000,8'h00,4'b0000, 4'b0000,8'h00,0,1,1,0,1));

        // Reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk_all("reset", '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        RESETN = 1'b1;

        for (int r = 0; r < tbl.size(); r++) begin
            drive(tbl[r].send, tbl[r].exb, tbl[r].sel, tbl[r].mask, tbl[r].data, tbl[r].ack);
            chk_all($sformatf("row%0d", r), tbl[r].e_send, tbl[r].e_data, tbl[r].e_cnt,
                    tbl[r].e_ack, tbl[r].e_cp, tbl[r].e_feb, tbl[r].e_err);
            @(posedge CLK);
            @(negedge CLK);
        end

        // Asynchronous reset while a copy token is partially delivered
        drive(1, 0, '0, 4'b1111, 8'h71, 4'b0000);
        @(posedge CLK); @(negedge CLK);
        drive(1, 0, '0, 4'b0011, 8'h72, 4'b0000);
        @(posedge CLK); @(negedge CLK);
        drive(0, 0, '0, '0, '0, 4'b0001);
        chk("mid SENDOUT", 32'(SENDOUT), 32'(4'b1111));
        chk("mid COUNT",   32'(COUNT),   32'd2);
        chk("mid ACKOUT",  32'(ACKOUT),  32'd0);
        @(posedge CLK); @(negedge CLK);
        drive(0, 0, '0, '0, '0, 4'b0000);
        chk("partial FEBOUT",  32'(FEBOUT),  32'd1);
        chk("partial SENDOUT", 32'(SENDOUT), 32'(4'b1110));
        #2 RESETN = 1'b0;
        #1 chk_all("async_reset", '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        RESETN = 1'b1;
        drive(0, 0, '0, '0, '0, 4'b1111);
        chk("release ACKOUT", 32'(ACKOUT), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge CLK); @(negedge CLK);
            chk_all($sformatf("post_reset%0d", c), '0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        end

        // Randomized traffic against the queue model
        mq.delete();
        m_done = '0; m_ack = 1'b1; m_cp = 1'b0; m_err = 1'b0;
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 2) != 0, 1'($urandom), SW'($urandom_range(0, 4)),
                  NOUT'($urandom), 8'($urandom),
                  ($urandom_range(0, 3) == 0) ? 4'b1111 : NOUT'($urandom));
            chk_all($sformatf("rand%0d", c), m_sendout(),
                    (mq.size() != 0) ? mq[0].data : 8'h00, CW'(mq.size()),
                    m_ack, m_cp, (mq.size() != 0) && (m_done != '0), m_err);
            @(posedge CLK);
            model_edge();
            @(negedge CLK);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/celement_exe_nway.md
Name: celement_exe_nway

Overview:
- Clocked, parametrised successor of the two-way exclusive-branch/copy C-element stage.
- Accepts tokens (payload plus routing) from one upstream SEND/ACK channel and buffers them in a DEPTH-entry FIFO.
- Each token is delivered either to exactly one of NOUT downstream channels (exclusive branch) or to any subset of them (copy).
- A copied token retires only when every selected channel has acknowledged it. The block sits between a token source and NOUT parallel pipeline branches.

Parameters:
- NOUT, 4, number of downstream channels (2..16).
- DW, 8, payload width.
- DEPTH, 2, FIFO entries (power of two, 2..16).
- SW, $clog2(NOUT), width of SELIN.
- CW, $clog2(DEPTH+1), width of COUNT.

Ports:
- CLK  in  1  clock, rising edge.
- RESETN  in  1  reset, asynchronous, active-low.
- SENDIN  in  1  upstream token valid.
- ACKOUT  out  1  upstream ready; a transfer occurs when SENDIN&ACKOUT are both high at a rising edge.
- DATAIN  in  DW  payload.
- EXBIN  in  1  1 = exclusive branch (SELIN), 0 = copy (MASKIN).
- SELIN  in  SW  branch destination index.
- MASKIN  in  NOUT  copy destination mask.
- SENDOUT  out  NOUT  per-channel token valid.
- ACKIN  in  NOUT  per-channel downstream ready.
- DATAOUT  out  DW  head payload, shared by all channels.
- CP  out  1  one-cycle pulse, registered, in the cycle after the head token retires.
- FEBOUT  out  1  high while the head token is partially delivered.
- ERR  out  1  sticky flag: a malformed token was received.
- COUNT  out  CW  number of FIFO entries occupied.

Behaviour:
- Reset (RESETN low, asynchronous): FIFO empty, COUNT=0, SENDOUT=0, DATAOUT=0, CP=0, FEBOUT=0, ERR=0, ACKOUT=0.
  - ACKOUT comes from a register. It goes to 1 on the first rising edge after RESETN deasserts.
- ACKOUT = registered !full. It is cleared on the edge at which the FIFO becomes full and set on the edge at which an entry frees.
  - No same-cycle pass-through: a retire and an enqueue in one cycle while full is not possible.
  - When not full, a simultaneous enqueue and retire leaves COUNT unchanged.
- Enqueue: the destination mask is computed at accept time as EXBIN ? onehot(SELIN) : MASKIN. It is stored with DATAIN.
- Malformed token (EXBIN=1 and SELIN>=NOUT, or EXBIN=0 and MASKIN==0):
  - The handshake completes normally.
  - The token is not stored and COUNT does not change.
  - ERR is set on that edge and stays high until reset.
- Head state machine, per head entry:
  - EMPTY: COUNT==0, SENDOUT=0.
  - DELIVER: head valid, done==0.
  - PARTIAL: head valid, done!=0 (FEBOUT=1).
- SENDOUT = head valid ? (mask & ~done) : 0. DATAOUT = head payload, or 0 when empty. Both are combinational from state only, never from ACKIN.
- Per channel i, delivery occurs when SENDOUT[i]&ACKIN[i] are high at an edge; done[i] is set on that edge.
- Retire: if (mask & ~done & ~delivered_now)==0 at an edge:
  - the head pops,
  - done clears,
  - CP=1 for the next cycle,
  - the state becomes DELIVER if another entry is present, else EMPTY.
  - Partial delivery without retire moves the state to PARTIAL.
- ACKIN[i] while SENDOUT[i]=0 is ignored.
- Latency: a token accepted at edge k shows SENDOUT at cycle k+1 when the FIFO was empty.
- Throughput: 1 token/cycle when all selected channels ack immediately.
- Copy ordering: channels may ack in any order and in any cycles. The head never advances until all selected channels are done, and each channel sees each token exactly once.
- Pointers wrap modulo DEPTH. COUNT saturates by construction: it never exceeds DEPTH and never underflows.
- Reset mid-operation discards all tokens and done bits immediately and clears CP/FEBOUT in the same instant.

Test Plan:
1. Reset, then release; drive SENDIN=1, EXBIN=1, SELIN=2, DATAIN=0xA5 for 1 cycle with ACKIN=4'b0100.
   -> Next cycle SENDOUT=4'b0100, DATAOUT=0xA5, FEBOUT=0. Following cycle CP=1, COUNT=0.
2. Copy token MASKIN=4'b1011, DATAIN=0x3C. Ack ch0 at cycle 1, ch3 at cycle 3, ch1 at cycle 5.
   -> SENDOUT goes 1011→1010→0010→0000. FEBOUT is high from cycle 2 until retire. CP is pulsed once, only after the ch1 ack.
3. ACKIN=0, push tokens continuously with DEPTH=2.
   -> COUNT reaches 2 and ACKOUT drops on the edge accepting the 2nd token. Third token held with no overwrite. Ack all → ACKOUT returns next cycle and the third token is accepted.
4. Malformed tokens: EXBIN=0, MASKIN=0, then EXBIN=1, SELIN=5 with NOUT=4.
   -> Both handshakes complete, COUNT stays 0, SENDOUT=0, ERR=1 and stays high until RESETN pulse.
5. Back-to-back branch tokens to ch0, ch1, ch2, ch3 with all ACKIN=1.
   -> One token per cycle, with SENDOUT one-hot and shifting each cycle and correct DATAOUT. CP high for 4 consecutive cycles. Pointer wrap verified over 8+ tokens.
6. Assert RESETN low mid-copy (PARTIAL, COUNT=2).
   -> All outputs return to reset values asynchronously. Post-release, SENDOUT=0 and the old tokens are never re-sent.
